tankb_sfx_engine: RTL

TANKB_SFX_ENGINE -- requirements
Module: tankb_sfx_engine

---
 rtl/tankb_sfx_pkg.sv | 36 +++
 rtl/tankb_sfx_voice.sv | 68 ++++++
 rtl/tankb_sfx_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tankb_sfx_pkg.sv
// Shared types, default parameters and sample helpers for the Tank Battalion
// sample-playback sound engine.
package tankb_sfx_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_EXP  = 2'd1,
        FETCH_FIRE = 2'd2,
        MIX        = 2'd3
    } fetch_state_t;

    typedef logic signed [15:0] sample_t;

    localparam int          DEF_CLK_DIV   = 1632;
    localparam int          DEF_EXP_LEN   = 52095;
    localparam int          DEF_FIRE_LEN  = 21791;
    localparam logic [16:0] DEF_EXP_BASE  = 17'h00000;
    localparam logic [16:0] DEF_FIRE_BASE = 17'h0CB80;

    // Offset-binary byte (0x80 = silence) to a full-scale signed sample;
    // the byte lands in the upper half so 0xFF maps to 32512 and 0x00 to -32768.
    function automatic sample_t byte_to_sample(input logic [7:0] b);
        return sample_t'({b ^ 8'h80, 8'h00});
    endfunction

    // Two-voice sum in 17 bits, clamped to the signed 16-bit range.
    function automatic sample_t sat_add(input sample_t a, input sample_t b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            return s[16] ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
        end
        return sample_t'(s[15:0]);
    endfunction

endpackage

// File: rtl/tankb_sfx_voice.sv
// One sample-playback voice: trigger edge detect, play position, end-of-sample
// detect and the most recently fetched sample.
module tankb_sfx_voice
    import tankb_sfx_pkg::*;
#(
    parameter int LEN = DEF_EXP_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic        busy,
    input  logic        ack,
    input  logic [7:0]  data,
    output logic        active,
    output logic [16:0] pos,
    output sample_t     level
);

    localparam logic [16:0] LEN_END = 17'(LEN);

    logic        trig_r;
    logic        trig_prev;
    logic        rise;
    logic        discard;
    logic [16:0] pos_inc;
    sample_t     sample;

    assign rise    = trig_r & ~trig_prev;
    assign pos_inc = pos + 17'd1;
    assign level   = active ? sample : sample_t'(16'h0000);

    // Register the latch level and keep one cycle of history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_r    <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_r    <= trig;
            trig_prev <= trig_r;
        end
    end

    // A rising edge (re)starts playback; an in-flight fetch is then marked for discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            pos     <= '0;
            sample  <= '0;
            discard <= 1'b0;
        end else if (rise) begin
            active  <= 1'b1;
            pos     <= '0;
            sample  <= '0;
            discard <= busy & ~ack;
        end else if (ack) begin
            if (discard) begin
                discard <= 1'b0;
            end else begin
                sample <= byte_to_sample(data);
                pos    <= pos_inc;
                if (pos_inc == LEN_END) begin
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tankb_sfx_engine.sv
// Tank Battalion explosion/fire sample engine: a tick divider paces a fetch FSM
// that reads one byte per active voice from sample memory and mixes them.
// Optional macro TANKB_SFX_LPF_EN adds a one-pole low-pass on the mixed output.
module tankb_sfx_engine
    import tankb_sfx_pkg::*;
#(
    parameter int          CLK_DIV   = DEF_CLK_DIV,
    parameter int          EXP_LEN   = DEF_EXP_LEN,
    parameter int          FIRE_LEN  = DEF_FIRE_LEN,
    parameter logic [16:0] EXP_BASE  = DEF_EXP_BASE,
    parameter logic [16:0] FIRE_BASE = DEF_FIRE_BASE
) (
    input  logic        CLK_18M,
    input  logic        RESET,
    input  logic        explode_trig,
    input  logic        fire_trig,
    output logic        rom_req,
    output logic [16:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output sample_t     audio_out,
    output logic        overrun
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic          req_n;
    logic [16:0]   addr_n;
    logic [CW-1:0] tick_cnt;
    logic          tick;

    logic          exp_active;
    logic          fire_active;
    logic [16:0]   exp_pos;
    logic [16:0]   fire_pos;
    sample_t       exp_level;
    sample_t       fire_level;
    logic          exp_busy;
    logic          fire_busy;
    sample_t       mix_sum;

    assign tick      = (tick_cnt == CW'(CLK_DIV - 1));
    assign exp_busy  = (state == FETCH_EXP) && rom_req;
    assign fire_busy = (state == FETCH_FIRE) && rom_req;
    assign mix_sum   = sat_add(exp_level, fire_level);

    tankb_sfx_voice #(.LEN(EXP_LEN)) u_exp (
        .clk    (CLK_18M),
        .rst    (RESET),
        .trig   (explode_trig),
        .busy   (exp_busy),
        .ack    (exp_busy & rom_ack),
        .data   (rom_data),
        .active (exp_active),
        .pos    (exp_pos),
        .level  (exp_level)
    );

    tankb_sfx_voice #(.LEN(FIRE_LEN)) u_fire (
        .clk    (CLK_18M),
        .rst    (RESET),
        .trig   (fire_trig),
        .busy   (fire_busy),
        .ack    (fire_busy & rom_ack),
        .data   (rom_data),
        .active (fire_active),
        .pos    (fire_pos),
        .level  (fire_level)
    );

    // Sample-rate divider: free-running count with a one-cycle tick at wrap.
    always_ff @(posedge CLK_18M or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // FSM state and registered memory request, so address stays put during a handshake.
    always_ff @(posedge CLK_18M or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            rom_req  <= 1'b0;
            rom_addr <= '0;
        end else begin
            state    <= state_n;
            rom_req  <= req_n;
            rom_addr <= addr_n;
        end
    end

    // Fetch sequencing: each FETCH state issues one request for an active voice, then moves on.
    always_comb begin
        state_n = state;
        req_n   = rom_req;
        addr_n  = rom_addr;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = FETCH_EXP;
                end
            end
            FETCH_EXP: begin
                if (rom_req) begin
                    if (rom_ack) begin
                        req_n   = 1'b0;
                        state_n = FETCH_FIRE;
                    end
                end else if (exp_active) begin
                    req_n  = 1'b1;
                    addr_n = EXP_BASE + exp_pos;
                end else begin
                    state_n = FETCH_FIRE;
                end
            end
            FETCH_FIRE: begin
                if (rom_req) begin
                    if (rom_ack) begin
                        req_n   = 1'b0;
                        state_n = MIX;
                    end
                end else if (fire_active) begin
                    req_n  = 1'b1;
                    addr_n = FIRE_BASE + fire_pos;
                end else begin
                    state_n = MIX;
                end
            end
            MIX: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Sticky flag for ticks that arrive while a previous sample is still in progress.
    always_ff @(posedge CLK_18M or posedge RESET) begin
        if (RESET) begin
            overrun <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

`ifdef TANKB_SFX_LPF_EN
    sample_t           lpf_y;
    logic signed [16:0] lpf_y_ext;
    logic signed [16:0] lpf_diff;
    logic signed [16:0] lpf_step;
    logic signed [16:0] lpf_next;

    assign lpf_y_ext = {lpf_y[15], lpf_y};
    assign lpf_diff  = {mix_sum[15], mix_sum} - lpf_y_ext;
    assign lpf_step  = lpf_diff >>> 2;
    assign lpf_next  = lpf_y_ext + lpf_step;
    assign audio_out = lpf_y;

    // Low-pass state moves a quarter of the way toward the new mix each sample.
    always_ff @(posedge CLK_18M or posedge RESET) begin
        if (RESET) begin
            lpf_y <= '0;
        end else if (state == MIX) begin
            lpf_y <= sample_t'(lpf_next[15:0]);
        end
    end
`else
    // Output register loads the saturated mix once per sample.
    always_ff @(posedge CLK_18M or posedge RESET) begin
        if (RESET) begin
            audio_out <= '0;
        end else if (state == MIX) begin
            audio_out <= mix_sum;
        end
    end
`endif

endmodule
